mult_pp_combiner: RTL and testbench

//  Consumer end of the Nios II multiply cell. Takes the four registered 16x16 partial

---
 rtl/mult_pp_combiner.sv | 134 +++++++++++++
 tb/tb_mult_pp_combiner.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_pp_combiner.sv
// mult_pp_combiner
//   Consumer end of the multiply cell. Combines four registered half-width partial
//   products into the full 2W-bit product over a 2-stage stallable pipeline and
//   returns the requested W-bit half together with an opaque destination tag.
//
//   p1 = lo*lo, p2 = lo(src1)*hi(src2), p3 = hi(src1)*lo(src2), p4 = hi*hi
//   product = p1 + ((p2 + p3) << HALF) + (p4 << W)   (mod 2^2W)
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   en                pipeline advance; 0 holds every register
//   flush             clears both valid bits on the next edge (wins over en)
//   pp_valid          p1..p4 and sideband are valid this cycle
//   pp_src1_signed    src1 signed (sign-extends p3, p4)
//   pp_src2_signed    src2 signed (sign-extends p2, p4)
//   pp_hi_sel         1 = return upper W bits, 0 = lower W bits
//   pp_tag            destination tag, passed through unchanged
//   p1..p4            partial products
//   res_valid         result valid
//   res_tag           tag of the returned result
//   res_data          selected half of the product
//   res_full          full 2W-bit product
module mult_pp_combiner #(
    parameter int unsigned W     = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             flush,
    input  logic             pp_valid,
    input  logic             pp_src1_signed,
    input  logic             pp_src2_signed,
    input  logic             pp_hi_sel,
    input  logic [TAG_W-1:0] pp_tag,
    input  logic [W-1:0]     p1,
    input  logic [W-1:0]     p2,
    input  logic [W-1:0]     p3,
    input  logic [W-1:0]     p4,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic [W-1:0]     res_data,
    output logic [2*W-1:0]   res_full
);

    localparam int unsigned HALF = W / 2;
    // Two extra bits: the sum of two sign- or zero-extended W-bit values needs W+2 signed bits.
    localparam int unsigned MW   = W + 2;
    localparam int unsigned SW   = 2 * W + 1;

    // ---------------------------------------------------------------------------------------
    // Stage 1 combinational: operand extension and middle-term sum
    // ---------------------------------------------------------------------------------------
    logic [MW-1:0] p2_ext;
    logic [MW-1:0] p3_ext;
    logic [MW-1:0] mid_next;
    logic          hiext_next;

    always_comb begin
        p2_ext     = pp_src2_signed ? {{2{p2[W-1]}}, p2} : {2'b00, p2};
        p3_ext     = pp_src1_signed ? {{2{p3[W-1]}}, p3} : {2'b00, p3};
        mid_next   = p2_ext + p3_ext;
        // p4 is a signed product whenever either operand is signed.
        hiext_next = (pp_src1_signed | pp_src2_signed) & p4[W-1];
    end

    // ---------------------------------------------------------------------------------------
    // Stage 1 registers
    // ---------------------------------------------------------------------------------------
    logic [MW-1:0]    s1_mid;
    logic [2*W-1:0]   s1_base;
    logic             s1_hiext;
    logic             s1_valid;
    logic             s1_hi_sel;
    logic [TAG_W-1:0] s1_tag;

    // ---------------------------------------------------------------------------------------
    // Stage 2 combinational: final 2W-bit sum
    // ---------------------------------------------------------------------------------------
    // s1_hiext only supplies the bit just above 2W; the sign fill of p4 beyond that position
    // falls off the modulo-2^2W result, so a single bit of it is carried.
    logic [SW-1:0]  base_wide;
    logic [SW-1:0]  mid_wide;
    logic [SW-1:0]  sum_wide;
    logic [2*W-1:0] sum;
    logic [W-1:0]   sel_half;
    logic           unused_sum_msb;

    always_comb begin
        base_wide      = {s1_hiext, s1_base};
        mid_wide       = {{(SW - MW){s1_mid[MW-1]}}, s1_mid} << HALF;
        sum_wide       = base_wide + mid_wide;
        sum            = sum_wide[2*W-1:0];
        unused_sum_msb = sum_wide[2*W];
        sel_half       = s1_hi_sel ? sum[2*W-1:W] : sum[W-1:0];
    end

    // ---------------------------------------------------------------------------------------
    // Pipeline registers
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_mid    <= '0;
            s1_base   <= '0;
            s1_hiext  <= 1'b0;
            s1_valid  <= 1'b0;
            s1_hi_sel <= 1'b0;
            s1_tag    <= '0;
            res_valid <= 1'b0;
            res_tag   <= '0;
            res_data  <= '0;
            res_full  <= '0;
        end else begin
            if (en) begin
                s1_mid    <= mid_next;
                s1_base   <= {p4, p1};
                s1_hiext  <= hiext_next;
                s1_valid  <= pp_valid;
                s1_hi_sel <= pp_hi_sel;
                s1_tag    <= pp_tag;
                res_full  <= sum;
                res_data  <= sel_half;
                res_valid <= s1_valid;
                res_tag   <= s1_tag;
            end
            // Flush kills in-flight ops regardless of en; data registers are don't-care.
            if (flush) begin
                s1_valid  <= 1'b0;
                res_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mult_pp_combiner.sv
// Testbench for mult_pp_combiner. Partial products come from a 16x16 split model of
// src1/src2; expected results are queued at issue time and popped by a monitor when the
// DUT presents a new result.
module tb_mult_pp_combiner;

    localparam int unsigned W     = 32;
    localparam int unsigned TAG_W = 5;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      full;
        logic [31:0]      data;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             en;
    logic             flush;
    logic             pp_valid;
    logic             pp_src1_signed;
    logic             pp_src2_signed;
    logic             pp_hi_sel;
    logic [TAG_W-1:0] pp_tag;
    logic [W-1:0]     p1, p2, p3, p4;
    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [W-1:0]     res_data;
    logic [2*W-1:0]   res_full;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    mult_pp_combiner #(.W(W), .TAG_W(TAG_W)) dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .flush          (flush),
        .pp_valid       (pp_valid),
        .pp_src1_signed (pp_src1_signed),
        .pp_src2_signed (pp_src2_signed),
        .pp_hi_sel      (pp_hi_sel),
        .pp_tag         (pp_tag),
        .p1             (p1),
        .p2             (p2),
        .p3             (p3),
        .p4             (p4),
        .res_valid      (res_valid),
        .res_tag        (res_tag),
        .res_data       (res_data),
        .res_full       (res_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------------------------------------------------------- reference models
    function automatic logic [31:0] pp16(input logic [15:0] x, input logic xs,
                                         input logic [15:0] y, input logic ys);
        logic [63:0] xv, yv, pr;
        xv = xs ? {{48{x[15]}}, x} : {48'b0, x};
        yv = ys ? {{48{y[15]}}, y} : {48'b0, y};
        pr = xv * yv;
        return pr[31:0];
    endfunction

    function automatic logic [63:0] prod64(input logic [31:0] a, input logic sa,
                                           input logic [31:0] b, input logic sb);
        logic [63:0] av, bv;
        av = sa ? {{32{a[31]}}, a} : {32'b0, a};
        bv = sb ? {{32{b[31]}}, b} : {32'b0, b};
        return av * bv;
    endfunction

    // Drives one op onto the inputs (caller owns en/flush); queues its expectation if push.
    task automatic set_op(input logic [31:0] a, input logic [31:0] b, input logic sa,
                          input logic sb, input logic hi, input logic [TAG_W-1:0] tag,
                          input logic [63:0] full, input bit push);
        exp_t e;
        p1             = pp16(a[15:0],  1'b0, b[15:0],  1'b0);
        p2             = pp16(a[15:0],  1'b0, b[31:16], sb);
        p3             = pp16(a[31:16], sa,   b[15:0],  1'b0);
        p4             = pp16(a[31:16], sa,   b[31:16], sb);
        pp_src1_signed = sa;
        pp_src2_signed = sb;
        pp_hi_sel      = hi;
        pp_tag         = tag;
        pp_valid       = 1'b1;
        if (push) begin
            e.tag  = tag;
            e.full = full;
            e.data = hi ? full[63:32] : full[31:0];
            sb_q.push_back(e);
        end
    endtask

    task automatic idle();
        pp_valid = 1'b0;
    endtask

    // ---------------------------------------------------------------- result monitor
    logic mon_en, mon_fl, mon_rst;
    exp_t mon_e;
    always begin
        @(posedge clk);
        mon_en  = en;
        mon_fl  = flush;
        mon_rst = reset;
        #1;
        if (!mon_rst && !reset && mon_en && !mon_fl && res_valid) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got tag %h full %h, want no result",
                         res_tag, res_full);
            end else begin
                mon_e = sb_q.pop_front();
                checks += 2;
                if (res_tag !== mon_e.tag) begin
                    errors++;
                    $display("FAIL res_tag: got %h want %h", res_tag, mon_e.tag);
                end
                if (res_full !== mon_e.full) begin
                    errors++;
                    $display("FAIL res_full(tag %h): got %h want %h", mon_e.tag, res_full,
                             mon_e.full);
                end
                if (res_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL res_data(tag %h): got %h want %h", mon_e.tag, res_data,
                             mon_e.data);
                end
            end
        end
    end

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        reset = 1'b1; en = 1'b1; flush = 1'b0;
        set_op(32'h5, 32'h7, 1'b0, 1'b0, 1'b0, 5'd9, 64'd35, 1'b0);
        #1;
        checks += 4;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", res_valid); end
        if (res_tag !== '0) begin errors++; $display("FAIL reset_tag: got %h want 0", res_tag); end
        if (res_data !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", res_data); end
        if (res_full !== '0) begin errors++; $display("FAIL reset_full: got %h want 0", res_full); end
        repeat (2) @(posedge clk);
        #1;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b want 0", res_valid); end
        if (res_full !== '0) begin errors++; $display("FAIL reset_hold_full: got %h want 0", res_full); end
        @(negedge clk);
        idle();
        reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid: got %b want 0", res_valid); end
    endtask

    task automatic test_unsigned();
        @(negedge clk);
        en = 1'b1;
        set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 5'd1, 64'hFFFFFFFE_00000001, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got %b want 0", res_valid); end
        @(negedge clk);
        set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5'd2, 64'hFFFFFFFE_00000001, 1'b1);
        @(posedge clk); #1;
        checks += 2;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL latency_2: got %b want 1", res_valid); end
        if (res_data !== 32'h0000_0001) begin errors++; $display("FAIL uu_lo_data: got %h want 00000001", res_data); end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks += 2;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL uu_hi_valid: got %b want 1", res_valid); end
        if (res_data !== 32'hFFFF_FFFE) begin errors++; $display("FAIL uu_hi_data: got %h want fffffffe", res_data); end
        @(posedge clk); #1;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL uu_drain_valid: got %b want 0", res_valid); end
        if (sb_q.size() != 0) begin errors++; $display("FAIL uu_queue: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_signed();
        @(negedge clk);
        en = 1'b1;
        set_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 5'd3, 64'h1, 1'b1);
        @(negedge clk);
        set_op(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 5'd4, 64'hFFFFFFFE_00000002, 1'b1);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL signed_queue: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] f2;
        f2 = prod64(32'h1234_5678, 1'b1, 32'h9ABC_DEF0, 1'b1);
        @(negedge clk);
        en = 1'b1;
        set_op(32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 5'd1, 64'd15, 1'b1);
        @(negedge clk);
        set_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b1, 1'b0, 5'd2, f2, 1'b1);
        @(negedge clk);
        // Op 3 sits on the inputs through the stall and must be captured exactly once.
        set_op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 5'd3, 64'h40000000_00000000, 1'b1);
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            checks += 3;
            if (res_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, res_valid); end
            if (res_tag !== 5'd1) begin errors++; $display("FAIL stall_tag[%0d]: got %h want 01", i, res_tag); end
            if (res_full !== 64'd15) begin errors++; $display("FAIL stall_full[%0d]: got %h want f", i, res_full); end
        end
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks++;
        if (res_tag !== 5'd3) begin errors++; $display("FAIL b2b_last_tag: got %h want 03", res_tag); end
        @(posedge clk); #1;
        checks += 2;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL b2b_dup: got %b want 0", res_valid); end
        if (sb_q.size() != 0) begin errors++; $display("FAIL b2b_queue: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_flush();
        @(negedge clk);
        en = 1'b1;
        set_op(32'd7, 32'd9, 1'b0, 1'b0, 1'b0, 5'd5, 64'd63, 1'b1);
        @(negedge clk);
        set_op(32'h0000_FFFF, 32'h0001_0001, 1'b0, 1'b0, 1'b0, 5'd6, 64'hFFFF_FFFF, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL preflush_valid: got %b want 1", res_valid); end
        @(negedge clk);
        sb_q.delete();
        idle();
        flush = 1'b1;
        en    = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", res_valid); end
        @(negedge clk);
        flush = 1'b0;
        en    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_stale[%0d]: got %b want 0", i, res_valid); end
        end
        // An op arriving together with flush is dropped.
        @(negedge clk);
        flush = 1'b1;
        set_op(32'd11, 32'd13, 1'b0, 1'b0, 1'b0, 5'd10, 64'd143, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        idle();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_drop[%0d]: got %b want 0", i, res_valid); end
        end
        @(negedge clk);
        set_op(32'hFFFF_FFF0, 32'd16, 1'b1, 1'b0, 1'b1, 5'd7, 64'hFFFFFFFF_FFFFFF00, 1'b1);
        @(posedge clk); #1;
        checks++;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL postflush_early: got %b want 0", res_valid); end
        @(negedge clk);
        idle();
        @(posedge clk); #1;
        checks += 2;
        if (res_valid !== 1'b1) begin errors++; $display("FAIL postflush_valid: got %b want 1", res_valid); end
        if (res_tag !== 5'd7) begin errors++; $display("FAIL postflush_tag: got %h want 07", res_tag); end
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin errors++; $display("FAIL flush_queue: got %0d pending want 0", sb_q.size()); end
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        en = 1'b1;
        set_op(32'd100, 32'd200, 1'b0, 1'b0, 1'b0, 5'd8, 64'd20000, 1'b1);
        @(negedge clk);
        set_op(32'hDEAD_BEEF, 32'h0000_0002, 1'b0, 1'b0, 1'b0, 5'd9, 64'h1_BD5B7DDE, 1'b1);
        @(negedge clk);
        idle();
        #2;
        reset = 1'b1;
        #1;
        checks += 4;
        if (res_valid !== 1'b0) begin errors++; $display("FAIL async_valid: got %b want 0", res_valid); end
        if (res_tag !== '0) begin errors++; $display("FAIL async_tag: got %h want 0", res_tag); end
        if (res_data !== '0) begin errors++; $display("FAIL async_data: got %h want 0", res_data); end
        if (res_full !== '0) begin errors++; $display("FAIL async_full: got %h want 0", res_full); end
        sb_q.delete();
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checks++;
            if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_stale[%0d]: got %b want 0", i, res_valid); end
        end
    endtask

    task automatic test_random();
        logic [31:0] corner [7];
        logic [31:0] a, b;
        logic        sa, sb, hi, v;
        int          issued;
        corner[0] = 32'h0;         corner[1] = 32'h1;         corner[2] = 32'hFFFF_FFFF;
        corner[3] = 32'h8000_0000; corner[4] = 32'h7FFF_FFFF; corner[5] = 32'h0000_FFFF;
        corner[6] = 32'h0001_0000;
        issued = 0;
        for (int i = 0; i < 20000 && issued < 10000; i++) begin
            @(negedge clk);
            en = ($urandom_range(0, 7) != 0);
            v  = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 6)] : $urandom();
            b  = ($urandom_range(0, 5) == 0) ? corner[$urandom_range(0, 6)] : $urandom();
            sa = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            hi = 1'($urandom_range(0, 1));
            if (v) begin
                set_op(a, b, sa, sb, hi, 5'($urandom_range(0, 31)), prod64(a, sa, b, sb), en);
                if (en) issued++;
            end else begin
                idle();
            end
        end
        @(negedge clk);
        en = 1'b1;
        idle();
        repeat (3) @(negedge clk);
        checks += 2;
        if (issued != 10000) begin errors++; $display("FAIL rand_issued: got %0d want 10000", issued); end
        if (sb_q.size() != 0) begin errors++; $display("FAIL rand_queue: got %0d pending want 0", sb_q.size()); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_back_to_back();
        test_flush();
        test_reset_inflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
